// File: rtl/vend_dispense.sv
// vend_dispense: releases the selected item through a req/ack handshake with the
// item motor, then pays change (or a full refund) one coin at a time through a
// req/ack handshake with the coin hopper. Keeps per-item stock counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for an end_trans rising edge
// S_LATCH  | one cycle: decide vend/refund, latch amounts and item
// S_VEND   | vend_req high until the item motor acks
// S_CHANGE | paying remaining change, one coin per req/ack
// S_DONE   | one-cycle done pulse
// S_FAULT  | handshake timed out; only reset leaves this state
module vend_dispense #(
  parameter int COIN_HI     = 10,
  parameter int COIN_MID    = 5,
  parameter int COIN_LO     = 1,
  parameter int STOCK_W     = 3,
  parameter int STOCK_INIT0 = 7,
  parameter int STOCK_INIT1 = 5,
  parameter int STOCK_INIT2 = 3,
  parameter int STOCK_INIT3 = 0,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       end_trans,
  input  logic [7:0] sum_money,
  input  logic [7:0] price,
  input  logic [1:0] item_select,
  output logic       vend_req,
  output logic [1:0] vend_item,
  input  logic       vend_ack,
  output logic       coin_req,
  output logic [1:0] coin_type,
  input  logic       coin_ack,
  output logic [7:0] change_out,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] stock_empty
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_VEND,
    S_CHANGE,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] HI_V  = 8'(COIN_HI);
  localparam logic [7:0] MID_V = 8'(COIN_MID);
  localparam logic [7:0] LO_V  = 8'(COIN_LO);

  // The timer counts down from ACK_TIMEOUT-1 while a req is outstanding, so a
  // req stays up for exactly ACK_TIMEOUT cycles before the fault is taken.
  localparam int TMR_W = ($clog2(ACK_TIMEOUT) < 1) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(ACK_TIMEOUT - 1);

  state_t state, state_nxt;

  logic               et_prev;
  logic [7:0]         remaining, remaining_nxt;
  logic [7:0]         change_nxt;
  logic [1:0]         item_nxt;
  logic               vreq_nxt;
  logic               creq_nxt;
  logic [1:0]         ctype_nxt;
  logic [1:0]         coin_pick;
  logic [TMR_W-1:0]   timer, timer_nxt;
  logic [STOCK_W-1:0] stock     [4];
  logic [STOCK_W-1:0] stock_nxt [4];
  logic               vend_ok;

  function automatic logic [7:0] coin_value(input logic [1:0] t);
    case (t)
      2'd2:    return HI_V;
      2'd1:    return MID_V;
      default: return LO_V;
    endcase
  endfunction

  // Greedy coin choice: largest coin not exceeding the amount still owed.
  always_comb begin
    coin_pick = 2'd0;
    if (remaining >= HI_V)
      coin_pick = 2'd2;
    else if (remaining >= MID_V)
      coin_pick = 2'd1;
  end

  // Next-state and next-datapath logic for the whole transaction sequence.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    change_nxt    = change_out;
    item_nxt      = vend_item;
    vreq_nxt      = vend_req;
    creq_nxt      = coin_req;
    ctype_nxt     = coin_type;
    timer_nxt     = timer;
    stock_nxt     = stock;
    vend_ok       = 1'b0;

    case (state)
      S_IDLE: begin
        if (end_trans && !et_prev)
          state_nxt = S_LATCH;
      end

      S_LATCH: begin
        vend_ok  = (sum_money >= price) && (stock[item_select] != '0);
        item_nxt = item_select;
        if (vend_ok) begin
          remaining_nxt = sum_money - price;
          change_nxt    = sum_money - price;
          vreq_nxt      = 1'b1;
          timer_nxt     = TMR_LOAD;
          state_nxt     = S_VEND;
        end else begin
          remaining_nxt = sum_money;
          change_nxt    = sum_money;
          state_nxt     = S_CHANGE;
        end
      end

      S_VEND: begin
        if (vend_ack) begin
          vreq_nxt = 1'b0;
          if (stock[vend_item] != '0)
            stock_nxt[vend_item] = stock[vend_item] - STOCK_W'(1);
          state_nxt = S_CHANGE;
        end else if (timer == '0) begin
          vreq_nxt  = 1'b0;
          state_nxt = S_FAULT;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end

      S_CHANGE: begin
        if (coin_req) begin
          if (coin_ack) begin
            // Dropping req here guarantees at least one low cycle between coins.
            remaining_nxt = remaining - coin_value(coin_type);
            creq_nxt      = 1'b0;
          end else if (timer == '0) begin
            creq_nxt  = 1'b0;
            state_nxt = S_FAULT;
          end else begin
            timer_nxt = timer - TMR_W'(1);
          end
        end else if (remaining == 8'd0) begin
          state_nxt = S_DONE;
        end else begin
          creq_nxt  = 1'b1;
          ctype_nxt = coin_pick;
          timer_nxt = TMR_LOAD;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      S_FAULT: begin
        vreq_nxt = 1'b0;
        creq_nxt = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Datapath registers; edge detector preset to 1 so a level held through reset is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      et_prev    <= 1'b1;
      remaining  <= 8'd0;
      change_out <= 8'd0;
      vend_item  <= 2'd0;
      vend_req   <= 1'b0;
      coin_req   <= 1'b0;
      coin_type  <= 2'd0;
      timer      <= '0;
      stock[0]   <= STOCK_W'(STOCK_INIT0);
      stock[1]   <= STOCK_W'(STOCK_INIT1);
      stock[2]   <= STOCK_W'(STOCK_INIT2);
      stock[3]   <= STOCK_W'(STOCK_INIT3);
    end else begin
      et_prev    <= end_trans;
      remaining  <= remaining_nxt;
      change_out <= change_nxt;
      vend_item  <= item_nxt;
      vend_req   <= vreq_nxt;
      coin_req   <= creq_nxt;
      coin_type  <= ctype_nxt;
      timer      <= timer_nxt;
      stock      <= stock_nxt;
    end
  end

  // Status outputs decoded from state and stock.
  always_comb begin
    busy  = (state != S_IDLE);
    done  = (state == S_DONE);
    fault = (state == S_FAULT);
    for (int i = 0; i < 4; i++)
      stock_empty[i] = (stock[i] == '0);
  end

endmodule
